// File: rtl/sw_ptr_regfile.sv
// sw_ptr_regfile: snoops TRN rx memory writes to a BAR window and captures 64-bit software pointers
module sw_ptr_regfile #(
  parameter int BARHIT = 2,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] REG_BASE = 12'h040
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           trn_rd,
  input  logic [7:0]            trn_rrem_n,
  input  logic                  trn_rsof_n,
  input  logic                  trn_reof_n,
  input  logic                  trn_rsrc_rdy_n,
  input  logic [6:0]            trn_rbar_hit_n,
  output logic [NUM_REGS*64-1:0] sw_ptr,
  output logic [NUM_REGS-1:0]   sw_ptr_upd,
  output logic [15:0]           drop_cnt
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-4:0] NR = (ADDR_W-3)'(NUM_REGS);
  typedef enum logic [2:0] {IDLE, HDR32, DAT32, HDR64, DAT64, DRAIN} state_t;
  state_t st, nxt;
  logic acc, sof, eof, hit, mwr32, mwr64, hdr_ok, a_ok;
  logic len2_q, hdr_ok_q, hi_q, stg_v;
  logic [IW-1:0] idx_q, stg_idx, a_idx, c_idx;
  logic [31:0] d0_q, stg_lo, c_d0, c_d1;
  logic [ADDR_W-1:0] addr, off;
  logic [9:0] len;
  logic [1:0] drop_n;
  logic [16:0] drop_sum;
  logic cm, c_len2, c_hi;
  logic unused;
  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
  assign acc = !trn_rsrc_rdy_n;
  assign sof = !trn_rsof_n;
  assign eof = !trn_reof_n;
  assign hit = !trn_rbar_hit_n[BARHIT];
  assign mwr32 = trn_rd[62:56] == 7'h40;
  assign mwr64 = trn_rd[62:56] == 7'h60;
  assign len = trn_rd[41:32];
  assign hdr_ok = trn_rd[3:0] == 4'hF && (len == 10'd1 || (len == 10'd2 && trn_rd[7:4] == 4'hF));
  // MWr32 carries addr[31:2] in the upper DW; MWr64 carries the low address DW in the lower half
  assign addr = st == HDR64 ? trn_rd[ADDR_W-1:0] : {trn_rd[ADDR_W+31:34], 2'b00};
  assign off = addr - REG_BASE;
  assign a_idx = off[IW+2:3];
  assign a_ok = hdr_ok_q && addr >= REG_BASE && off[ADDR_W-1:3] < NR && !(len2_q && addr[2]);
  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_n};
  assign unused = ^{trn_rrem_n, trn_rd, trn_rbar_hit_n, off};
  always_comb begin
    nxt = st;
    cm = 1'b0;
    drop_n = 2'd0;
    c_len2 = len2_q;
    c_hi = hi_q;
    c_idx = idx_q;
    c_d0 = d0_q;
    c_d1 = bswap(trn_rd[31:0]);
    if (acc && sof) begin
      nxt = eof ? IDLE : !hit ? DRAIN : mwr32 ? HDR32 : mwr64 ? HDR64 : DRAIN;
      drop_n = 2'(st inside {HDR32, DAT32, HDR64, DAT64}) + 2'(hit && (mwr32 || mwr64) && eof);
    end else if (acc) begin
      case (st)
        HDR32: begin
          cm = a_ok && !len2_q && eof;
          c_len2 = 1'b0;
          c_hi = addr[2];
          c_idx = a_idx;
          c_d0 = bswap(trn_rd[31:0]);
          nxt = eof ? IDLE : (a_ok && len2_q) ? DAT32 : DRAIN;
          drop_n = {1'b0, !(a_ok && (len2_q != eof))};
        end
        DAT32: begin
          cm = eof;
          c_d1 = bswap(trn_rd[63:32]);
          nxt = eof ? IDLE : DRAIN;
          drop_n = {1'b0, !eof};
        end
        HDR64: begin
          nxt = eof ? IDLE : a_ok ? DAT64 : DRAIN;
          drop_n = {1'b0, !(a_ok && !eof)};
        end
        DAT64: begin
          cm = eof;
          c_d0 = bswap(trn_rd[63:32]);
          nxt = eof ? IDLE : DRAIN;
          drop_n = {1'b0, !eof};
        end
        DRAIN: nxt = eof ? IDLE : DRAIN;
        default: nxt = st;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      sw_ptr <= '0;
      sw_ptr_upd <= '0;
      drop_cnt <= '0;
      stg_v <= 1'b0;
      stg_idx <= '0;
      stg_lo <= '0;
      len2_q <= 1'b0;
      hdr_ok_q <= 1'b0;
      hi_q <= 1'b0;
      idx_q <= '0;
      d0_q <= '0;
    end else begin
      st <= nxt;
      sw_ptr_upd <= '0;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (acc && sof) begin
        len2_q <= len == 10'd2;
        hdr_ok_q <= hdr_ok;
      end
      if (acc && !sof && (st == HDR32 || st == HDR64)) begin
        hi_q <= addr[2];
        idx_q <= a_idx;
        d0_q <= bswap(trn_rd[31:0]);
      end
      // a low-half 1-DW write is parked in the single stage until its high half arrives
      if (cm && c_len2) begin
        sw_ptr[64*c_idx +: 64] <= {c_d1, c_d0};
        sw_ptr_upd[c_idx] <= 1'b1;
        if (stg_idx == c_idx) stg_v <= 1'b0;
      end else if (cm && !c_hi) begin
        stg_v <= 1'b1;
        stg_idx <= c_idx;
        stg_lo <= c_d0;
      end else if (cm) begin
        sw_ptr[64*c_idx +: 64] <= {c_d0, (stg_v && stg_idx == c_idx) ? stg_lo : sw_ptr[64*c_idx +: 32]};
        sw_ptr_upd[c_idx] <= 1'b1;
        stg_v <= 1'b0;
      end
    end
endmodule
